// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path (and the future transmitter).
package uart_pkg;

    localparam int unsigned OVERSAMPLE    = 16;
    // Widest supported frame; narrower words are zero-extended into this field.
    localparam int unsigned RX_DATA_WIDTH = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    typedef struct packed {
        logic                     ferr;
        logic                     perr;
        logic [RX_DATA_WIDTH-1:0] data;
    } rx_entry_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with fill level; head reads as zero when empty.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("uart_sync_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

    // NOTE: storage is deliberately not reset; only pointers and count are, and the
    // head is masked while empty, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: 16x oversampling with 3-sample majority vote, optional parity, 1/2 stop bits,
// error-tagged words into an FWFT FIFO. Define UART_RX_BREAK_DETECT_EN to add rx_break.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 32'd100_000_000,
    parameter int unsigned BAUD_RATE       = 32'd115200,
    parameter int unsigned WORD_WIDTH      = 32'd8,
    parameter logic [1:0]  PARITY          = 2'd0,
    parameter int unsigned STOP_BITS       = 32'd1,
    parameter int unsigned FIFO_DEPTH      = 32'd16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rxd,
    output logic [WORD_WIDTH-1:0]             dout,
    output logic                              dout_perr,
    output logic                              dout_ferr,
    output logic                              empty,
    input  logic                              re,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              overrun,
    input  logic                              clr_overrun,
    output logic                              rx_busy
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                              rx_break
`endif
);

    localparam int unsigned DIV   = CLOCK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  TICK_S0    = OS_W'(7);
    localparam logic [OS_W-1:0]  TICK_S1    = OS_W'(8);
    localparam logic [OS_W-1:0]  TICK_VOTE  = OS_W'(9);
    localparam logic [OS_W-1:0]  TICK_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       LAST_DATA  = 4'(WORD_WIDTH - 1);
    localparam logic [3:0]       LAST_STOP  = 4'(STOP_BITS - 1);
    localparam parity_e          PAR_MODE   = parity_e'(PARITY);

    if (DIV < 1) begin : g_div_check
        $error("uart_rx_fifo: CLOCK_FREQUENCY too low for 16x oversampling of BAUD_RATE");
    end
    if (PARITY == 2'd3) begin : g_parity_check
        $error("uart_rx_fifo: PARITY=3 is illegal");
    end
    if (WORD_WIDTH < 5 || WORD_WIDTH > RX_DATA_WIDTH) begin : g_width_check
        $error("uart_rx_fifo: WORD_WIDTH must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
        $error("uart_rx_fifo: STOP_BITS must be 1 or 2");
    end

    logic                  rxd_meta_q, rxd_sync_q, rxd_prev_q;
    rx_state_e             state_q, state_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [OS_W-1:0]       os_cnt_q, os_cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [1:0]            samp_q, samp_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  overrun_q, overrun_d;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                  par_bit_q, par_bit_d;
    logic                  stop_one_q, stop_one_d;
    logic                  rx_break_q, rx_break_d;
    logic                  is_break;
`endif

    logic      tick, sample_now, bit_end, voted, start_edge, ferr_now, par_expected;
    logic      push_req, fifo_full;
    rx_entry_t push_entry, head_entry;
    logic      unused_head;

    assign start_edge   = rxd_prev_q && !rxd_sync_q;
    assign tick         = (state_q != RX_IDLE) && (div_cnt_q == DIV_LAST);
    assign sample_now   = tick && (os_cnt_q == TICK_VOTE);
    assign bit_end      = tick && (os_cnt_q == TICK_LAST);
    assign voted        = majority3(samp_q[0], samp_q[1], rxd_sync_q);
    assign ferr_now     = ferr_q | ~voted;
    assign par_expected = (PAR_MODE == PAR_ODD) ? ~(^shift_q) : ^shift_q;
`ifdef UART_RX_BREAK_DETECT_EN
    assign is_break     = (shift_q == '0) && !par_bit_q && !stop_one_q && !voted;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            state_q    <= RX_IDLE;
            div_cnt_q  <= '0;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            samp_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_q  <= 1'b0;
            stop_one_q <= 1'b0;
            rx_break_q <= 1'b0;
`endif
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            os_cnt_q   <= os_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            samp_q     <= samp_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            overrun_q  <= overrun_d;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_q  <= par_bit_d;
            stop_one_q <= stop_one_d;
            rx_break_q <= rx_break_d;
`endif
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        os_cnt_d   = os_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        samp_d     = samp_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        push_req   = 1'b0;
        push_entry = '0;
`ifdef UART_RX_BREAK_DETECT_EN
        par_bit_d  = par_bit_q;
        stop_one_d = stop_one_q;
        rx_break_d = 1'b0;
`endif

        // Oversampling clock runs only inside a frame and restarts at every start edge.
        if (state_q == RX_IDLE) begin
            div_cnt_d = '0;
            os_cnt_d  = '0;
        end else if (tick) begin
            div_cnt_d = '0;
            os_cnt_d  = os_cnt_q + OS_W'(1);
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        if (tick && os_cnt_q == TICK_S0) samp_d[0] = rxd_sync_q;
        if (tick && os_cnt_q == TICK_S1) samp_d[1] = rxd_sync_q;

        case (state_q)
            RX_IDLE: begin
                if (start_edge) begin
                    state_d   = RX_START;
                    bit_cnt_d = '0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                    par_bit_d  = 1'b0;
                    stop_one_d = 1'b0;
`endif
                end
            end
            RX_START: begin
                if (sample_now && voted) begin
                    state_d = RX_IDLE;
                end else if (bit_end) begin
                    state_d = RX_DATA;
                end
            end
            RX_DATA: begin
                if (sample_now) begin
                    shift_d = {voted, shift_q[WORD_WIDTH-1:1]};
                end
                if (bit_end) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PAR_MODE == PAR_NONE) ? RX_STOP : RX_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (sample_now) begin
                    perr_d = voted ^ par_expected;
`ifdef UART_RX_BREAK_DETECT_EN
                    par_bit_d = voted;
`endif
                end
                if (bit_end) begin
                    state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (sample_now) begin
                    ferr_d = ferr_now;
`ifdef UART_RX_BREAK_DETECT_EN
                    stop_one_d = stop_one_q | voted;
`endif
                    if (bit_cnt_q == LAST_STOP) begin
                        push_entry.ferr = ferr_now;
                        push_entry.perr = perr_q;
                        push_entry.data = RX_DATA_WIDTH'(shift_q);
`ifdef UART_RX_BREAK_DETECT_EN
                        if (is_break) begin
                            rx_break_d = 1'b1;
                            state_d    = RX_BREAK;
                        end else begin
                            push_req = 1'b1;
                            state_d  = RX_IDLE;
                        end
`else
                        push_req = 1'b1;
                        state_d  = RX_IDLE;
`endif
                    end
                end else if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
`ifdef UART_RX_BREAK_DETECT_EN
            RX_BREAK: begin
                if (rxd_sync_q) begin
                    state_d = RX_IDLE;
                end
            end
`endif
            default: state_d = RX_IDLE;
        endcase
    end

    // A drop sets the flag even when software clears it in the same cycle.
    always_comb begin
        overrun_d = overrun_q;
        if (clr_overrun) overrun_d = 1'b0;
        if (push_req && fifo_full && !re) overrun_d = 1'b1;
    end

    uart_sync_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req),
        .wdata_i (push_entry),
        .pop_i   (re),
        .rdata_o (head_entry),
        .empty_o (empty),
        .full_o  (fifo_full),
        .count_o (count)
    );

    assign dout        = head_entry.data[WORD_WIDTH-1:0];
    assign dout_perr   = head_entry.perr;
    assign dout_ferr   = head_entry.ferr;
    assign unused_head = ^head_entry.data;
    assign overrun     = overrun_q;
    assign rx_busy     = (state_q != RX_IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
    assign rx_break    = rx_break_q;
`endif

endmodule
